seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered successor to the team's 5-bit combinational ALU (x, y, select, cin → f, cout). Widens the datapath to WIDTH bits and adds a 3-bit opcode, a multi-cycle shift-add multiplier, and status flags. Exchanges operands and results over valid/ready handshakes, so it can sit between a register-file read stage and a writeback stage.

## Interface
- WIDTH, 5, operand/result width; legal range 2..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- op  in  3  operation select.
- cin  in  1  carry/borrow in; used by ADD and SUB only.
- out_valid  out  1  result registers hold an undelivered result.
- out_ready  in  1  consumer takes the result this cycle.
- f  out  WIDTH  result, or low half of the product.
- f_hi  out  WIDTH  high half of the product; 0 for all other ops.
- cout  out  1  ADD carry out, or SUB borrow out; 0 otherwise.
- zero  out  1  result is all zeros; for MUL, tests {f_hi,f}.
- ovf  out  1  signed overflow, ADD/SUB only; 0 otherwise.
- err  out  1  illegal opcode (110, 111).

## Operation
- Opcodes:
  - 000 ADD: {cout,f} = x + y + cin.
  - 001 SUB: f = x − y − cin modulo 2^WIDTH; cout = 1 when x < y + cin (unsigned borrow).
  - 010 AND. 011 OR. 100 XOR.
  - 101 MUL: unsigned product, {f_hi,f} = x·y, 2·WIDTH bits.
  - 110/111: f = 0, err = 1, all other flags 0.
- ovf:
  - ADD: operands share a sign bit and f's sign differs.
  - SUB: operand signs differ and f's sign ≠ x's sign.
- FSM states:
  - IDLE: accepts a bundle when in_valid & in_ready.
    - Non-MUL op: computes combinationally from the captured inputs and loads the result registers on the accept edge; stays in IDLE.
    - MUL: latches x as multiplicand, y as multiplier, clears the 2·WIDTH accumulator and iteration counter; goes to MUL.
  - MUL: one shift-add iteration per cycle. When multiplier bit 0 is 1, add the multiplicand into the accumulator's upper half, then shift right 1 keeping the carry. After WIDTH iterations, load {f_hi,f} and flags, set out_valid, return to IDLE.
- in_ready = (state == IDLE) & (!out_valid | out_ready). A new result may load on the same edge that the old one drains.
- Result registers (f, f_hi, flags, err) hold stable while out_valid = 1 and out_ready = 0.
- out_valid clears on the edge where out_valid & out_ready, unless a new result loads on that same edge.
- Operands are sampled only at acceptance. Input changes during MUL do not affect the result.

## Timing
- Reset: state = IDLE, out_valid = 0, f = f_hi = 0, cout = zero = ovf = err = 0, counter = 0. After reset, in_ready = 1 on the first cycle.
- Non-MUL op: accepted at edge N; out_valid = 1 and result visible after edge N (latency 1).
- MUL: accepted at edge N; in_ready = 0 for cycles N..N+WIDTH−1; out_valid rises after edge N+WIDTH (latency WIDTH).
- Back-to-back single-cycle ops with out_ready held at 1: one result per cycle.
- rst asserted during MUL or with out_valid = 1 aborts. The result is discarded, and the reset values appear after that edge.
- Simultaneous in_valid and drain with out_valid = 1 and out_ready = 1: old result is consumed and new result loads on the same edge, with no bubble.
- Arithmetic is computed in WIDTH+1 bits for ADD/SUB and in 2·WIDTH bits for MUL; no other widening.

## Test plan (WIDTH = 5)
- ADD x=10010, y=00010, cin=0 → f=10100, cout=0, ovf=0, zero=0, valid 1 cycle after accept. Then x=01010, y=01111, cin=1 → f=11010, cout=0, ovf=1.
- SUB x=10100, y=00111, cin=0 → f=01101, cout=0, ovf=1. Then x=00010, y=01110 → f=10100, cout=1.
- AND x=01010, y=01111 → f=01010. XOR of the same operands → f=00101. XOR x=y → f=00000, zero=1.
- MUL x=00010, y=01110 → {f_hi,f}=00000_11100. in_ready low for 5 cycles; out_valid rises 5 cycles after accept. Also 11111·11111 → 11110_00001.
- Backpressure: hold out_ready=0 after ADD → f stable and in_ready=0 for 4 cycles. Raise out_ready with in_valid=1 → drain and new accept on the same edge.
- Illegal op 110 → f=0, err=1. Assert rst 2 cycles into a MUL → out_valid=0, all outputs 0, in_ready=1 on the next cycle, no stale result.

Source files
------------

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add unsigned multiplier.
module seq_alu #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   f_q;
  logic [WIDTH-1:0]   f_hi_q;
  logic               cout_q;
  logic               zero_q;
  logic               ovf_q;
  logic               err_q;
  logic               out_valid_q;

  logic               accept;
  logic               drain;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_f_d;
  logic             alu_cout_d;
  logic             alu_ovf_d;
  logic             alu_err_d;
  logic             alu_zero_d;

  assign add_w = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_f_d    = '0;
    alu_cout_d = 1'b0;
    alu_ovf_d  = 1'b0;
    alu_err_d  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_f_d    = add_w[WIDTH-1:0];
        alu_cout_d = add_w[WIDTH];
        alu_ovf_d  = (x[WIDTH-1] == y[WIDTH-1]) && (add_w[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f_d    = sub_w[WIDTH-1:0];
        alu_cout_d = sub_w[WIDTH];
        alu_ovf_d  = (x[WIDTH-1] != y[WIDTH-1]) && (sub_w[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND:  alu_f_d = x & y;
      OP_OR:   alu_f_d = x | y;
      OP_XOR:  alu_f_d = x ^ y;
      default: alu_err_d = 1'b1;
    endcase
    // Illegal opcodes report only err, so zero stays low despite f = 0.
    alu_zero_d = (alu_f_d == '0) && !alu_err_d;
  end

  // One shift-add step: add into the upper half, then shift right keeping the carry.
  logic [WIDTH:0]     part_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic               acc_lsb_unused;

  assign part_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                        + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_d          = {part_sum, acc_q[WIDTH-1:1]};
  assign acc_lsb_unused = acc_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      f_q         <= '0;
      f_hi_q      <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (drain) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand_q  <= x;
              mplier_q <= y;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              f_q         <= alu_f_d;
              f_hi_q      <= '0;
              cout_q      <= alu_cout_d;
              zero_q      <= alu_zero_d;
              ovf_q       <= alu_ovf_d;
              err_q       <= alu_err_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            f_q         <= acc_d[WIDTH-1:0];
            f_hi_q      <= acc_d[2*WIDTH-1:WIDTH];
            cout_q      <= 1'b0;
            zero_q      <= (acc_d == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign f_hi      = f_hi_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH = 5 with hand-computed expected results.
module tb_seq_alu;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [2:0]   op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic [W-1:0] f_hi;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         err;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .op       (op),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .f_hi     (f_hi),
    .cout     (cout),
    .zero     (zero),
    .ovf      (ovf),
    .err      (err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] ef, input logic [W-1:0] efh,
                            input logic ec, input logic ez, input logic eo, input logic ee);
    check({tag, ".valid"}, 64'(out_valid), 64'(1));
    check({tag, ".f"},     64'(f),    64'(ef));
    check({tag, ".f_hi"},  64'(f_hi), 64'(efh));
    check({tag, ".cout"},  64'(cout), 64'(ec));
    check({tag, ".zero"},  64'(zero), 64'(ez));
    check({tag, ".ovf"},   64'(ovf),  64'(eo));
    check({tag, ".err"},   64'(err),  64'(ee));
    $display("[TB] %s f_hi=%b f=%b cout=%b zero=%b ovf=%b err=%b",
             tag, f_hi, f, cout, zero, ovf, err);
  endtask

  // Present one bundle for a single edge; in_ready must already be high.
  task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    op = o; x = a; y = b; cin = c;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ef, input logic [W-1:0] efh, input logic ez);
    int lat;
    issue(tag, 3'b101, a, b, 1'b0);
    check({tag, ".busy"}, 64'(in_ready), 64'(0));
    x = ~a; y = ~b;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (out_valid) break;
      check({tag, ".busy"}, 64'(in_ready), 64'(0));
    end
    check({tag, ".latency"}, 64'(lat), 64'(W));
    expect_res(tag, ef, efh, 1'b0, ez, 1'b0, 1'b0);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; op = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'(0));
    check("rst.f",     64'({f_hi, f}), 64'(0));
    check("rst.flags", 64'({cout, zero, ovf, err}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'(1));

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    issue("add1", 3'b000, 5'b10010, 5'b00010, 1'b0);
    expect_res("add1", 5'b10100, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("hold.f",        64'(f),         64'(5'b10100));
      check("hold.valid",    64'(out_valid), 64'(1));
      check("hold.in_ready", 64'(in_ready),  64'(0));
    end
    out_ready = 1'b1;
    issue("add2", 3'b000, 5'b01010, 5'b01111, 1'b1);
    expect_res("add2", 5'b11010, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back single-cycle ops, one result per cycle.
    issue("sub1", 3'b001, 5'b10100, 5'b00111, 1'b0);
    expect_res("sub1", 5'b01101, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("sub2", 3'b001, 5'b00010, 5'b01110, 1'b0);
    expect_res("sub2", 5'b10100, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("and", 3'b010, 5'b01010, 5'b01111, 1'b0);
    expect_res("and", 5'b01010, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("or", 3'b011, 5'b01010, 5'b00101, 1'b0);
    expect_res("or", 5'b01111, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("xor", 3'b100, 5'b01010, 5'b01111, 1'b0);
    expect_res("xor", 5'b00101, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("xor0", 3'b100, 5'b01010, 5'b01010, 1'b0);
    expect_res("xor0", 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("ill", 3'b110, 5'b01010, 5'b01111, 1'b1);
    expect_res("ill", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    run_mul("mul1", 5'b00010, 5'b01110, 5'b11100, 5'b00000, 1'b0);
    run_mul("mul2", 5'b11111, 5'b11111, 5'b00001, 5'b11110, 1'b0);

    // Reset two cycles into a multiply must discard it.
    issue("mulrst", 3'b101, 5'b00011, 5'b00011, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.valid",    64'(out_valid), 64'(0));
    check("abort.f",        64'({f_hi, f}), 64'(0));
    check("abort.flags",    64'({cout, zero, ovf, err}), 64'(0));
    check("abort.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1;
    end
    check("abort.no_stale", 64'(seen_valid), 64'(0));
    check("abort.ready",    64'(in_ready),   64'(1));
    $display("[TB] reset during MUL: out_valid=%b in_ready=%b", out_valid, in_ready);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
